// File: rtl/cam_buf_rd_ctrl.sv
// Round-robin frame-buffer read controller: synchronises per-buffer full levels,
// walks pixel addresses under back-pressure and hands each buffer back to the writer.
module cam_buf_rd_ctrl #(
  parameter int IMG_W   = 480,
  parameter int IMG_H   = 272,
  parameter int NUM_BUF = 2,
  parameter int ADDR_W  = 17,
  parameter int RD_LAT  = 1,
  parameter int FR_SYNC = 1,
  parameter int SEL_W   = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1
) (
  input  logic               iClk,
  input  logic               wRsn,
  input  logic               wEnClk,
  input  logic [NUM_BUF-1:0] iBufFull,
  input  logic               iFrDone,
  input  logic               iDsRdy,
  output logic               oRdEn,
  output logic [ADDR_W-1:0]  oRdAddr,
  output logic [SEL_W-1:0]   oBufSel,
  output logic               oValid,
  output logic               oRdDone,
  output logic [NUM_BUF-1:0] oBufRelease,
  output logic [7:0]         oOvrCnt
);

  localparam int TOTAL = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(TOTAL - 1);
  localparam logic [1:0]        DRAIN_LAST = 2'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, WAIT, RELEASE} state_t;

  state_t             state_q, state_d;
  logic [NUM_BUF-1:0] sync1_q, sync2_q, sync3_q;
  logic [NUM_BUF-1:0] pending_q, pending_d;
  logic [SEL_W-1:0]   sel_q, sel_d, last_q, last_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic [1:0]         dcnt_q, dcnt_d;
  logic               fr_seen_q, fr_seen_d;
  logic [RD_LAT-1:0]  vpipe_q, vpipe_d, dpipe_q, dpipe_d;
  logic [7:0]         ovr_q, ovr_d;
  logic [NUM_BUF-1:0] rise, ovr_vec, release_vec;
  logic               rd_en, found;
  logic [SEL_W-1:0]   pick;

  assign rise = sync2_q & ~sync3_q;

  // An edge coinciding with its own release starts a new frame, not an overrun.
  for (genvar gi = 0; gi < NUM_BUF; gi++) begin : g_ovr
    assign ovr_vec[gi] = rise[gi] & pending_q[gi] & ~release_vec[gi];
  end

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= NUM_BUF; k++) begin
      if (!found && pending_q[(int'(last_q) + k) % NUM_BUF]) begin
        found = 1'b1;
        pick  = SEL_W'((int'(last_q) + k) % NUM_BUF);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    dcnt_d      = dcnt_q;
    fr_seen_d   = fr_seen_q;
    release_vec = '0;
    rd_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (wEnClk && found) begin
          sel_d   = pick;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        rd_en = iDsRdy && wEnClk;
        if (rd_en) begin
          if (cnt_q == LAST_ADDR) begin
            dcnt_d  = '0;
            state_d = (RD_LAT > 1) ? DRAIN : ((FR_SYNC != 0) ? WAIT : RELEASE);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (wEnClk) begin
          if (dcnt_q == DRAIN_LAST) state_d = (FR_SYNC != 0) ? WAIT : RELEASE;
          else                      dcnt_d  = dcnt_q + 1'b1;
        end
      end
      WAIT: begin
        // Frame-done may pulse on a disabled cycle; remember it until the next enable.
        if (iFrDone) fr_seen_d = 1'b1;
        if (wEnClk && (iFrDone || fr_seen_q)) begin
          fr_seen_d = 1'b0;
          state_d   = RELEASE;
        end
      end
      RELEASE: begin
        if (wEnClk) begin
          release_vec = NUM_BUF'(1) << sel_q;
          last_d      = sel_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pending_d = (pending_q & ~release_vec) | rise;
    ovr_d     = ((|ovr_vec) && (ovr_q != 8'hFF)) ? ovr_q + 8'd1 : ovr_q;
    vpipe_d   = vpipe_q;
    dpipe_d   = dpipe_q;
    if (wEnClk) begin
      vpipe_d = (vpipe_q << 1) | RD_LAT'(rd_en);
      dpipe_d = (dpipe_q << 1) | RD_LAT'(rd_en && (cnt_q == LAST_ADDR));
    end
  end

  always_ff @(posedge iClk or negedge wRsn) begin
    if (!wRsn) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      sync3_q   <= '0;
      state_q   <= IDLE;
      pending_q <= '0;
      sel_q     <= '0;
      last_q    <= SEL_W'(NUM_BUF - 1);
      cnt_q     <= '0;
      dcnt_q    <= '0;
      fr_seen_q <= 1'b0;
      vpipe_q   <= '0;
      dpipe_q   <= '0;
      ovr_q     <= '0;
    end else begin
      sync1_q   <= iBufFull;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      state_q   <= state_d;
      pending_q <= pending_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      dcnt_q    <= dcnt_d;
      fr_seen_q <= fr_seen_d;
      vpipe_q   <= vpipe_d;
      dpipe_q   <= dpipe_d;
      ovr_q     <= ovr_d;
    end
  end

  assign oRdEn       = rd_en;
  assign oRdAddr     = cnt_q;
  assign oBufSel     = sel_q;
  assign oValid      = vpipe_q[RD_LAT-1];
  assign oRdDone     = dpipe_q[RD_LAT-1];
  assign oBufRelease = release_vec;
  assign oOvrCnt     = ovr_q;

endmodule

// File: tb/tb_cam_buf_rd_ctrl.sv
// Directed bench: A = 4 buffers, RD_LAT 1, frame-synced; B = 2 buffers, RD_LAT 3, free-running release.
module tb_cam_buf_rd_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       a_en, a_frd, a_rdy, a_rden, a_valid, a_done;
  logic [3:0] a_full, a_rel;
  logic [5:0] a_addr;
  logic [1:0] a_sel;
  logic [7:0] a_ovr;

  logic       b_en, b_frd, b_rdy, b_rden, b_valid, b_done;
  logic [1:0] b_full, b_rel;
  logic [4:0] b_addr;
  logic [0:0] b_sel;
  logic [7:0] b_ovr;

  cam_buf_rd_ctrl #(.IMG_W(8), .IMG_H(4), .NUM_BUF(4), .ADDR_W(6), .RD_LAT(1), .FR_SYNC(1)) dut_a (
    .iClk(clk), .wRsn(rst_n), .wEnClk(a_en), .iBufFull(a_full), .iFrDone(a_frd), .iDsRdy(a_rdy),
    .oRdEn(a_rden), .oRdAddr(a_addr), .oBufSel(a_sel), .oValid(a_valid), .oRdDone(a_done),
    .oBufRelease(a_rel), .oOvrCnt(a_ovr));

  cam_buf_rd_ctrl #(.IMG_W(8), .IMG_H(4), .NUM_BUF(2), .ADDR_W(5), .RD_LAT(3), .FR_SYNC(0)) dut_b (
    .iClk(clk), .wRsn(rst_n), .wEnClk(b_en), .iBufFull(b_full), .iFrDone(b_frd), .iDsRdy(b_rdy),
    .oRdEn(b_rden), .oRdAddr(b_addr), .oBufSel(b_sel), .oValid(b_valid), .oRdDone(b_done),
    .oBufRelease(b_rel), .oOvrCnt(b_ovr));

  bit         which;
  logic       obs_rden, obs_valid, obs_done;
  logic [2:0] obs_sel;
  logic [3:0] obs_rel;
  logic [7:0] obs_addr, obs_ovr;

  always_comb begin
    obs_rden  = which ? b_rden  : a_rden;
    obs_valid = which ? b_valid : a_valid;
    obs_done  = which ? b_done  : a_done;
    obs_sel   = which ? {2'b00, b_sel} : {1'b0, a_sel};
    obs_rel   = which ? {2'b00, b_rel} : a_rel;
    obs_addr  = which ? {3'b000, b_addr} : {2'b00, a_addr};
    obs_ovr   = which ? b_ovr : a_ovr;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit rdy, input bit en, input bit frd);
    if (which) begin b_rdy = rdy; b_en = en; b_frd = frd; end
    else       begin a_rdy = rdy; a_en = en; a_frd = frd; end
  endtask

  task automatic wait_rden(input int exp_n, input string tag);
    int  n    = 0;
    bit  seen = 1'b0;
    while (n < 20 && !seen) begin
      adv();
      n++;
      @(negedge clk);
      seen = obs_rden;
    end
    chk(tag, n, exp_n);
  endtask

  // Starts at the negedge of the first RUN cycle; models address, valid/done pipeline and release.
  task automatic read_frame(input int sel, input int lat, input int stall_at, input int stall_len,
                            input bit toggle, input int gap_at, input int frd_at,
                            input int tail_n, input int rel_at);
    int   addr = 0, post = 0, stalled = 0, gapped = 0, s_now = -1;
    bit   done = 1'b0, frd_sent = 1'b0, cur_rdy = 1'b1, cur_en = 1'b1, rden_e, frd;
    bit   hist_v[4], hist_d[4];
    logic [3:0]  rel_e;
    logic [31:0] obs, exp;
    for (int j = 0; j < 4; j++) begin hist_v[j] = 1'b0; hist_d[j] = 1'b0; end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rden_e = !done && cur_rdy && cur_en;
      rel_e  = (done && post == rel_at) ? (4'b0001 << sel) : 4'b0000;
      exp = {14'd0, rden_e, hist_v[lat-1], hist_d[lat-1], 3'(sel), rel_e, done ? 8'd0 : 8'(addr)};
      obs = {14'd0, obs_rden, obs_valid, obs_done, obs_sel, obs_rel, done ? 8'd0 : obs_addr};
      chk($sformatf("frame buf%0d addr%0d post%0d", sel, addr, post), obs, exp);
      if (toggle && s_now == 9)    chk("ovr_first", obs_ovr, 1);
      if (toggle && s_now == 1526) chk("ovr_254", obs_ovr, 254);
      if (cur_en) begin
        for (int j = 3; j > 0; j--) begin hist_v[j] = hist_v[j-1]; hist_d[j] = hist_d[j-1]; end
        hist_v[0] = rden_e;
        hist_d[0] = rden_e && (addr == 31);
      end
      if (rden_e) begin
        if (addr == 31) done = 1'b1;
        else            addr++;
      end
      if (done) begin
        if (post == tail_n) break;
        post++;
      end
      adv();
      cur_rdy = 1'b1;
      cur_en  = 1'b1;
      s_now   = -1;
      if (!done && addr == gap_at && gapped < 3) begin
        cur_en = 1'b0;
        gapped++;
      end else if (!done && addr == stall_at && stalled < stall_len) begin
        cur_rdy = 1'b0;
        s_now   = stalled;
        if (toggle) b_full[sel] = ((stalled % 6) >= 3);
        stalled++;
      end
      frd = 1'b0;
      if (!done && addr == frd_at && !frd_sent) begin frd = 1'b1; frd_sent = 1'b1; end
      drive(cur_rdy, cur_en, frd);
      @(negedge clk);
    end
    chk($sformatf("frame_complete buf%0d", sel), done, 1);
  endtask

  task automatic a_release(input int sel);
    adv();
    a_frd = 1'b1;
    @(negedge clk);
    chk("wait_hold", {a_rden, a_rel}, 5'b0);
    adv();
    a_frd = 1'b0;
    @(negedge clk);
    chk($sformatf("release buf%0d", sel), {a_rden, a_rel}, {1'b0, 4'b0001 << sel});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    which = 1'b0;
    rst_n = 1'b0;
    a_en = 1'b1; a_frd = 1'b0; a_rdy = 1'b1; a_full = '0;
    b_en = 1'b1; b_frd = 1'b0; b_rdy = 1'b1; b_full = '0;
    #3;
    chk("reset_a", {a_rden, a_valid, a_done, a_sel, a_rel, a_addr, a_ovr}, 0);
    chk("reset_b", {b_rden, b_valid, b_done, b_sel, b_rel, b_addr, b_ovr}, 0);
    adv();
    adv();
    rst_n = 1'b1;

    // A: buffers 2 and 0 fill together; 0 goes first, with a 5-cycle stall at address 10.
    adv();
    a_full = 4'b0101;
    wait_rden(4, "latency_buf0");
    read_frame(0, 1, 10, 5, 1'b0, -1, -1, 4, 0);
    a_release(0);
    wait_rden(2, "rr_next_buf2");
    read_frame(2, 1, -1, 0, 1'b0, 20, 3, 4, 0);
    a_release(2);
    chk("ovr_a_none", a_ovr, 0);
    for (int i = 0; i < 5; i++) begin
      adv();
      @(negedge clk);
      chk($sformatf("a_idle%0d", i), {a_rden, a_rel}, 5'b0);
    end

    // B: buffer 1 read while its full bit toggles 300 times during a long stall.
    which = 1'b1;
    adv();
    b_full = 2'b10;
    wait_rden(4, "latency_b_buf1");
    read_frame(1, 3, 1, 1800, 1'b1, -1, 2, 10, 3);
    chk("ovr_saturated", b_ovr, 255);

    // A: start buffer 3 and reset mid-frame.
    which = 1'b0;
    adv();
    a_full = 4'b0000;
    b_full = 2'b00;
    for (int i = 0; i < 3; i++) begin
      adv();
      @(negedge clk);
      chk($sformatf("a_quiet%0d", i), a_rden, 0);
    end
    adv();
    a_full = 4'b1000;
    wait_rden(4, "latency_buf3");
    chk("sel_buf3", a_sel, 3);
    for (int k = 0; k <= 5; k++) begin
      chk($sformatf("pre_reset addr%0d", k), {a_rden, a_addr}, {1'b1, 6'(k)});
      if (k < 5) begin
        adv();
        @(negedge clk);
      end
    end
    #1;
    rst_n  = 1'b0;
    a_full = 4'b0000;
    #1;
    chk("midframe_reset_a", {a_rden, a_valid, a_done, a_sel, a_rel, a_addr, a_ovr}, 0);
    chk("midframe_reset_b_ovr", b_ovr, 0);
    adv();
    adv();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      adv();
      @(negedge clk);
      chk($sformatf("post_reset%0d", i), {a_rden, a_valid, a_rel, a_ovr, b_rden, b_rel}, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
